// File: rtl/gmii_port_arbiter_pkg.sv
// Shared types and constants for the GMII uplink frame arbiter.
// Holds the arbiter FSM encoding, the mode codes and a saturating counter helper.
package gmii_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    // Mode code 3 is treated like MODE_SEL by the top level.
    localparam logic [1:0] MODE_SEL = 2'd0;
    localparam logic [1:0] MODE_RR  = 2'd1;
    localparam logic [1:0] MODE_PRI = 2'd2;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gmii_port_arbiter_rr_arbiter.sv
// Combinational channel picker: round-robin search starting after ptr,
// or lowest-index-first when mode_pri is set.
module rr_arbiter
    import gmii_port_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          mode_pri,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] index,
    output logic          any
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            if (mode_pri) begin
                idx = k;
            end else begin
                idx = (int'(ptr) + 1 + k) % N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                index    = CW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/gmii_port_arbiter.sv
// N-channel GMII frame arbiter: switches source FIFOs onto one uplink only at
// frame boundaries, enforces the inter-frame gap and truncates over-long frames.
module gmii_port_arbiter
    import gmii_port_arbiter_pkg::*;
#(
    parameter  int N_CH       = 2,
    parameter  int IFG_CYCLES = 12,
    parameter  int MAX_LEN    = 1522,
    localparam int CW         = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   ch_pkt_rdy,
    input  logic [8*N_CH-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_last,
    input  logic [N_CH-1:0]   ch_err,
    output logic [N_CH-1:0]   ch_rd,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     sel,
    input  logic [N_CH-1:0]   ch_en,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    output logic              tx_er,
    output logic              busy,
    output logic [CW-1:0]     cur_chan,
    output logic              frame_trunc
);

    localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_LEN - 1);
    // GAP hands over to IDLE early enough that IDLE plus the first pop cycle complete the gap.
    localparam logic [CNT_W-1:0] GAP_EXIT = CNT_W'(IFG_CYCLES - 2);

    arb_state_e        state_q, state_d;
    logic [CW-1:0]     grant_q, grant_d;
    logic [N_CH-1:0]   grant_oh_q, grant_oh_d;
    logic [CW-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              tx_er_q, tx_er_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     cur_chan_q, cur_chan_d;
    logic              trunc_q, trunc_d;

    logic [N_CH-1:0]   sel_mask;
    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   arb_gnt;
    logic [CW-1:0]     arb_idx;
    logic              arb_any;
    logic              arb_mode_pri;
    logic [7:0]        head_data;
    logic              head_last;
    logic              head_err;

    // An out-of-range sel matches no channel, so nothing becomes eligible.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_mask[i] = (sel == CW'(i));
        end
        elig = ch_pkt_rdy & ch_en;
        if (mode != MODE_RR && mode != MODE_PRI) begin
            elig = elig & sel_mask;
        end
    end

    assign arb_mode_pri = (mode != MODE_RR);

    rr_arbiter #(.N(N_CH)) u_rr_arbiter (
        .req      (elig),
        .ptr      (rr_q),
        .mode_pri (arb_mode_pri),
        .gnt      (arb_gnt),
        .index    (arb_idx),
        .any      (arb_any)
    );

    always_comb begin
        head_data = '0;
        head_last = 1'b0;
        head_err  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_q == CW'(i)) begin
                head_data = ch_data[8*i +: 8];
                head_last = ch_last[i];
                head_err  = ch_err[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_d       = rr_q;
        len_d      = len_q;
        busy_d     = busy_q;
        cur_chan_d = cur_chan_q;
        tx_data_d  = '0;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        trunc_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_idx;
                    grant_oh_d = arb_gnt;
                    cur_chan_d = arb_idx;
                    busy_d     = 1'b1;
                    len_d      = '0;
                    state_d    = ST_XFER;
                    if (mode == MODE_RR) begin
                        rr_d = arb_idx;
                    end
                end
            end
            ST_XFER: begin
                tx_en_d   = 1'b1;
                tx_data_d = head_data;
                tx_er_d   = head_err;
                len_d     = sat_inc(len_q);
                // A last byte that lands exactly on MAX_LEN is a normal end, not a truncation.
                if (head_last) begin
                    state_d = ST_GAP;
                    busy_d  = 1'b0;
                end else if (len_q == LEN_LAST) begin
                    tx_er_d = 1'b1;
                    trunc_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                len_d = sat_inc(len_q);
                if (head_last) begin
                    state_d = ST_GAP;
                    busy_d  = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_EXIT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        gap_d = tx_en_d ? '0 : sat_inc(gap_q);
    end

    // The gap counter resets saturated so the first frame after reset is not held back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_q       <= CW'(N_CH - 1);
            len_q      <= '0;
            gap_q      <= '1;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            busy_q     <= 1'b0;
            cur_chan_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_q       <= rr_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            busy_q     <= busy_d;
            cur_chan_q <= cur_chan_d;
            trunc_q    <= trunc_d;
        end
    end

    assign ch_rd       = (state_q == ST_XFER || state_q == ST_DRAIN) ? grant_oh_q : '0;
    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;
    assign tx_er       = tx_er_q;
    assign busy        = busy_q;
    assign cur_chan    = cur_chan_q;
    assign frame_trunc = trunc_q;

endmodule

// File: tb/tb_gmii_port_arbiter.sv
// Self-checking bench for gmii_port_arbiter: behavioural source FIFOs feed the DUT,
// a per-channel scoreboard plus an expected channel order is checked on the uplink.
module tb_gmii_port_arbiter;

    localparam int N_CH    = 4;
    localparam int IFG     = 12;
    localparam int MAX_LEN = 100;

    typedef struct packed {
        logic       last;
        logic       err;
        logic [7:0] data;
    } src_ent_t;

    typedef struct packed {
        logic       er;
        logic [7:0] data;
    } exp_ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   ch_pkt_rdy;
    logic [8*N_CH-1:0] ch_data;
    logic [N_CH-1:0]   ch_last;
    logic [N_CH-1:0]   ch_err;
    logic [N_CH-1:0]   ch_rd;
    logic [1:0]        mode;
    logic [1:0]        sel;
    logic [N_CH-1:0]   ch_en;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_er;
    logic              busy;
    logic [1:0]        cur_chan;
    logic              frame_trunc;

    src_ent_t src_q [N_CH][$];
    exp_ent_t exp_q [N_CH][$];
    int       order_q[$];
    int       frames_pend [N_CH];
    int       pop_cnt [N_CH];

    int n_checks = 0;
    int n_fail   = 0;
    int frames_done = 0;
    int frames_started = 0;
    int trunc_cnt = 0;
    int low_cnt = 0;
    int cur_len = 0;
    int mon_ch = 0;
    bit mon_en = 1'b0;
    bit in_frame = 1'b0;
    bit seen_frame = 1'b0;
    bit gap_check = 1'b0;
    logic [N_CH-1:0] rd_seen = '0;

    always #5 clk = ~clk;

    gmii_port_arbiter #(
        .N_CH       (N_CH),
        .IFG_CYCLES (IFG),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_pkt_rdy  (ch_pkt_rdy),
        .ch_data     (ch_data),
        .ch_last     (ch_last),
        .ch_err      (ch_err),
        .ch_rd       (ch_rd),
        .mode        (mode),
        .sel         (sel),
        .ch_en       (ch_en),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_er       (tx_er),
        .busy        (busy),
        .cur_chan    (cur_chan),
        .frame_trunc (frame_trunc)
    );

    // Source FIFO model: pops on the edge where ch_rd was high, then presents the new head.
    initial begin
        logic [N_CH-1:0] rd_s;
        src_ent_t e;
        for (int i = 0; i < N_CH; i++) begin
            frames_pend[i] = 0;
            pop_cnt[i] = 0;
        end
        ch_pkt_rdy = '0;
        ch_data = '0;
        ch_last = '0;
        ch_err = '0;
        forever begin
            @(posedge clk);
            rd_s = ch_rd;
            #1;
            for (int i = 0; i < N_CH; i++) begin
                if (rd_s[i]) begin
                    n_checks++;
                    if (src_q[i].size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL pop_empty ch%0d: popped=1 required=0", i);
                    end else begin
                        e = src_q[i].pop_front();
                        pop_cnt[i]++;
                        if (e.last) frames_pend[i]--;
                    end
                end
            end
            for (int i = 0; i < N_CH; i++) begin
                if (src_q[i].size() > 0) begin
                    ch_data[8*i +: 8] = src_q[i][0].data;
                    ch_last[i] = src_q[i][0].last;
                    ch_err[i] = src_q[i][0].err;
                end else begin
                    ch_data[8*i +: 8] = 8'h00;
                    ch_last[i] = 1'b0;
                    ch_err[i] = 1'b0;
                end
                ch_pkt_rdy[i] = (frames_pend[i] > 0);
            end
        end
    end

    // Uplink monitor and scoreboard, sampled on the falling edge.
    initial begin
        exp_ent_t x;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                rd_seen = rd_seen | ch_rd;
                if (frame_trunc) trunc_cnt++;
                if (ch_rd != '0) begin
                    n_checks++;
                    if ($countones(ch_rd) != 1) begin
                        n_fail++;
                        $display("[TB] FAIL rd_onehot: got %b required one bit", ch_rd);
                    end
                end
                if (tx_en) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        cur_len = 0;
                        frames_started++;
                        n_checks++;
                        if (order_q.size() == 0) begin
                            n_fail++;
                            mon_ch = int'(cur_chan);
                            $display("[TB] FAIL unexpected_frame: got ch%0d required none", cur_chan);
                        end else begin
                            mon_ch = order_q.pop_front();
                            if (int'(cur_chan) != mon_ch) begin
                                n_fail++;
                                $display("[TB] FAIL frame_chan: got %0d required %0d", cur_chan, mon_ch);
                            end
                        end
                        if (gap_check && seen_frame) begin
                            n_checks++;
                            if (low_cnt != IFG) begin
                                n_fail++;
                                $display("[TB] FAIL ifg: got %0d idle cycles required %0d", low_cnt, IFG);
                            end
                        end
                    end
                    cur_len++;
                    n_checks++;
                    if (exp_q[mon_ch].size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL extra_byte ch%0d: got %h required none", mon_ch, tx_data);
                    end else begin
                        x = exp_q[mon_ch].pop_front();
                        if (tx_data !== x.data || tx_er !== x.er) begin
                            n_fail++;
                            $display("[TB] FAIL byte ch%0d #%0d: got %h/er%b required %h/er%b",
                                     mon_ch, cur_len, tx_data, tx_er, x.data, x.er);
                        end
                    end
                    low_cnt = 0;
                end else begin
                    if (in_frame) begin
                        in_frame = 1'b0;
                        seen_frame = 1'b1;
                        frames_done++;
                    end
                    low_cnt++;
                end
            end
        end
    end

    task automatic add_frame(input int ch, input int len, input int err_pos);
        src_ent_t e;
        exp_ent_t x;
        for (int b = 1; b <= len; b++) begin
            e.data = {2'(ch), 6'($urandom)};
            e.last = (b == len);
            e.err = (b == err_pos);
            src_q[ch].push_back(e);
            if (b <= MAX_LEN) begin
                x.data = e.data;
                x.er = e.err | (len > MAX_LEN && b == MAX_LEN);
                exp_q[ch].push_back(x);
            end
        end
        frames_pend[ch]++;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int cyc = 0;
        while (frames_done < target && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (frames_done < target) begin
            n_fail++;
            $display("[TB] FAIL %s_timeout: got %0d frames required %0d", name, frames_done, target);
        end
    endtask

    task automatic check_drained(input string name);
        for (int i = 0; i < N_CH; i++) begin
            n_checks++;
            if (exp_q[i].size() != 0) begin
                n_fail++;
                $display("[TB] FAIL %s_left ch%0d: got %0d bytes pending required 0", name, i, exp_q[i].size());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'd0;
        sel = 2'd0;
        ch_en = '0;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_tx_data: got %h required 00", tx_data); end
        if (tx_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_tx_en: got %b required 0", tx_en); end
        if (tx_er !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_tx_er: got %b required 0", tx_er); end
        if (ch_rd !== '0) begin n_fail++; $display("[TB] FAIL rst_ch_rd: got %b required 0", ch_rd); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        if (cur_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_cur_chan: got %0d required 0", cur_chan); end
        if (frame_trunc !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_trunc: got %b required 0", frame_trunc); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got busy=%b tx_en=%b required 0/0", busy, tx_en);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_fixed_select();
        int base = frames_done;
        int p1 = pop_cnt[1];
        mode = 2'd0;
        sel = 2'd1;
        ch_en = '1;
        gap_check = 1'b1;
        seen_frame = 1'b0;
        rd_seen = '0;
        for (int f = 0; f < 3; f++) begin
            add_frame(1, 64, 0);
            order_q.push_back(1);
            add_frame(0, 64, 0);
        end
        wait_frames(base + 3, 2000, "fixed_sel");
        n_checks += 2;
        if (rd_seen[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL sel_ch0_rd: got 1 required 0"); end
        if (pop_cnt[1] - p1 != 192) begin n_fail++; $display("[TB] FAIL sel_pops: got %0d required 192", pop_cnt[1] - p1); end
        mode = 2'd3;
        sel = 2'd0;
        seen_frame = 1'b0;
        for (int f = 0; f < 3; f++) order_q.push_back(0);
        wait_frames(base + 6, 2000, "mode3_sel");
        check_drained("fixed_sel");
    endtask

    task automatic test_round_robin();
        int base = frames_done;
        mode = 2'd1;
        gap_check = 1'b1;
        seen_frame = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < N_CH; c++) begin
                add_frame(c, 60, 0);
                order_q.push_back(c);
            end
        end
        wait_frames(base + 12, 3000, "round_robin");
        check_drained("round_robin");
    endtask

    task automatic test_priority();
        int base = frames_done;
        int st = frames_started;
        int cyc = 0;
        mode = 2'd2;
        gap_check = 1'b1;
        seen_frame = 1'b0;
        add_frame(3, 64, 0);
        order_q.push_back(3);
        while (frames_started < st + 1 && cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        add_frame(2, 64, 0);
        add_frame(0, 64, 0);
        order_q.push_back(0);
        order_q.push_back(2);
        wait_frames(base + 3, 1500, "priority");
        check_drained("priority");
    endtask

    task automatic test_truncation();
        int base = frames_done;
        int t0 = trunc_cnt;
        int p = pop_cnt[1];
        mode = 2'd2;
        gap_check = 1'b0;
        add_frame(1, 150, 0);
        add_frame(1, MAX_LEN, 0);
        add_frame(1, 1, 1);
        for (int f = 0; f < 3; f++) order_q.push_back(1);
        wait_frames(base + 3, 1500, "truncation");
        n_checks += 2;
        if (trunc_cnt - t0 != 1) begin n_fail++; $display("[TB] FAIL trunc_pulses: got %0d required 1", trunc_cnt - t0); end
        if (pop_cnt[1] - p != 251) begin n_fail++; $display("[TB] FAIL trunc_pops: got %0d required 251", pop_cnt[1] - p); end
        check_drained("truncation");
    endtask

    task automatic test_error_byte();
        int base = frames_done;
        mode = 2'd2;
        gap_check = 1'b0;
        add_frame(0, 64, 10);
        order_q.push_back(0);
        wait_frames(base + 1, 500, "error_byte");
        check_drained("error_byte");
    endtask

    task automatic test_reset_mid_frame();
        int base;
        int cyc = 0;
        mode = 2'd1;
        gap_check = 1'b0;
        add_frame(0, 20, 0);
        add_frame(2, 64, 0);
        order_q.push_back(0);
        order_q.push_back(2);
        while (!(in_frame && mon_ch == 2 && cur_len >= 30) && cyc < 1000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (!(in_frame && mon_ch == 2 && cur_len >= 30)) begin
            n_fail++;
            $display("[TB] FAIL midframe_timeout: got len %0d required 30", cur_len);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks += 7;
        if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL async_tx_data: got %h required 00", tx_data); end
        if (tx_en !== 1'b0) begin n_fail++; $display("[TB] FAIL async_tx_en: got %b required 0", tx_en); end
        if (tx_er !== 1'b0) begin n_fail++; $display("[TB] FAIL async_tx_er: got %b required 0", tx_er); end
        if (ch_rd !== '0) begin n_fail++; $display("[TB] FAIL async_ch_rd: got %b required 0", ch_rd); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL async_busy: got %b required 0", busy); end
        if (cur_chan !== 2'd0) begin n_fail++; $display("[TB] FAIL async_cur_chan: got %0d required 0", cur_chan); end
        if (frame_trunc !== 1'b0) begin n_fail++; $display("[TB] FAIL async_trunc: got %b required 0", frame_trunc); end
        mon_en = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            frames_pend[i] = 0;
        end
        order_q.delete();
        in_frame = 1'b0;
        seen_frame = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        base = frames_done;
        add_frame(3, 20, 0);
        add_frame(0, 20, 0);
        order_q.push_back(0);
        order_q.push_back(3);
        wait_frames(base + 2, 500, "post_reset_rr");
        check_drained("post_reset_rr");
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_round_robin();
        test_priority();
        test_truncation();
        test_error_byte();
        test_reset_mid_frame();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
